// File: rtl/transform_setup_builder.sv
`default_nettype none
// ============================================================================
// Module      : transform_setup_builder
// Description : Converts a per-triangle transform setup packet into the matrix
//               form used by the model->world and world->camera stages.
//               Builds Euler rotation matrices R = Rz*Ry*Rx from supplied
//               sin/cos values with a single shared Q16.16 multiplier, one
//               product per cycle (14 steps per matrix), and caches the last
//               model and camera matrices. A matrix is rebuilt only when its
//               valid flag is set; otherwise the cached copy is emitted.
// Ports       : clk      - system clock
//               rst_n    - synchronous active-low reset
//               s_valid  - input packet valid
//               s_ready  - block can accept a packet (registered, IDLE only)
//               s_data   - {triangle, model xf, camera xf, model_vld, cam_vld}
//               m_valid  - output packet valid
//               m_ready  - downstream accepts
//               m_data   - {triangle, model matrix_xf, camera matrix_xf}
// Revision    : 1.0 - initial release
// ============================================================================
module transform_setup_builder (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [1057:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [1247:0] m_data
);

    typedef struct packed { logic [31:0] x; logic [31:0] y; logic [31:0] z; } point3d_t;
    typedef struct packed { point3d_t v0; point3d_t v1; point3d_t v2; } triangle_t;
    typedef struct packed {
        point3d_t pos; point3d_t rot_sin; point3d_t rot_cos; point3d_t scale;
    } transform_t;
    typedef struct packed {
        triangle_t  triangle;
        transform_t model;
        transform_t camera;
        logic       model_transform_valid;
        logic       camera_transform_valid;
    } transform_setup_t;
    // Row-major, R11 in the most significant word, R33 in word 0.
    typedef logic [8:0][31:0] rot_mtx_t;
    typedef struct packed { rot_mtx_t rot_mtx; point3d_t pos; point3d_t scale; } matrix_transform_t;
    typedef struct packed {
        triangle_t triangle; matrix_transform_t model; matrix_transform_t camera;
    } model_world_t;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_BUILD_MODEL  = 2'd1,
        ST_BUILD_CAMERA = 2'd2,
        ST_OUTPUT       = 2'd3
    } state_e;

    localparam logic [31:0] c_one       = 32'h0001_0000;
    localparam logic [3:0]  c_last_step = 4'd13;
    // Destination codes: 0..8 are matrix words, 9/10 the two intermediates.
    localparam logic [3:0]  c_r11 = 4'd8, c_r12 = 4'd7, c_r13 = 4'd6;
    localparam logic [3:0]  c_r21 = 4'd5, c_r22 = 4'd4, c_r23 = 4'd3;
    localparam logic [3:0]  c_r31 = 4'd2, c_r32 = 4'd1, c_r33 = 4'd0;
    localparam logic [3:0]  c_sxsy = 4'd9, c_cxsy = 4'd10;
    localparam logic [1:0]  c_op_set = 2'd0, c_op_add = 2'd1, c_op_sub = 2'd2;
    localparam matrix_transform_t c_mtx_reset = {
        c_one, 32'd0, 32'd0, 32'd0, c_one, 32'd0, 32'd0, 32'd0, c_one,
        96'd0, c_one, c_one, c_one};

    // Bit-exact Q16.16 multiply: drop 4 LSBs of each operand, 56-bit signed
    // product, arithmetic shift right by 8, keep the low word.
    function automatic logic [31:0] mul_fx(input logic [31:0] a, input logic [31:0] b);
        logic signed [27:0] ta;
        logic signed [27:0] tb;
        logic signed [55:0] p;
        ta = a[31:4];
        tb = b[31:4];
        p  = ta * tb;
        p  = p >>> 8;
        return 32'(p);
    endfunction

    transform_setup_t  w_in;
    state_e            r_state_q, w_state_d;
    triangle_t         r_tri_q, w_tri_d;
    transform_t        r_model_xf_q, w_model_xf_d;
    transform_t        r_camera_xf_q, w_camera_xf_d;
    logic              r_cam_flag_q, w_cam_flag_d;
    logic [3:0]        r_step_q, w_step_d;
    rot_mtx_t          r_mtx_q, w_mtx_d;
    logic [31:0]       r_sxsy_q, w_sxsy_d, r_cxsy_q, w_cxsy_d;
    matrix_transform_t r_model_q, w_model_d, r_camera_q, w_camera_d;
    logic              r_s_ready_q, w_s_ready_d;
    logic              r_m_valid_q, w_m_valid_d;
    model_world_t      r_m_data_q, w_m_data_d;

    transform_t  w_xf;
    logic [31:0] w_sx, w_sy, w_sz, w_cx, w_cy, w_cz;
    logic [31:0] w_op_a, w_op_b, w_prod, w_prev, w_acc;
    logic [3:0]  w_dst;
    logic [1:0]  w_op;

    assign w_in = s_data;
    assign w_xf = (r_state_q == ST_BUILD_CAMERA) ? r_camera_xf_q : r_model_xf_q;
    assign w_sx = w_xf.rot_sin.x;
    assign w_sy = w_xf.rot_sin.y;
    assign w_sz = w_xf.rot_sin.z;
    assign w_cx = w_xf.rot_cos.x;
    assign w_cy = w_xf.rot_cos.y;
    assign w_cz = w_xf.rot_cos.z;

    // Build sequencer: operand pair, destination and accumulate mode per step.
    // Two-term entries are written with the first product, then combined with
    // the second product on the following step.
    always_comb begin
        w_op_a = w_sx;
        w_op_b = w_sy;
        w_dst  = c_sxsy;
        w_op   = c_op_set;
        case (r_step_q)
            4'd0:  begin w_op_a = w_sx;     w_op_b = w_sy; w_dst = c_sxsy; end
            4'd1:  begin w_op_a = w_cx;     w_op_b = w_sy; w_dst = c_cxsy; end
            4'd2:  begin w_op_a = w_cy;     w_op_b = w_cz; w_dst = c_r11;  end
            4'd3:  begin w_op_a = r_sxsy_q; w_op_b = w_cz; w_dst = c_r12;  end
            4'd4:  begin w_op_a = w_cx;     w_op_b = w_sz; w_dst = c_r12; w_op = c_op_sub; end
            4'd5:  begin w_op_a = r_cxsy_q; w_op_b = w_cz; w_dst = c_r13;  end
            4'd6:  begin w_op_a = w_sx;     w_op_b = w_sz; w_dst = c_r13; w_op = c_op_add; end
            4'd7:  begin w_op_a = w_cy;     w_op_b = w_sz; w_dst = c_r21;  end
            4'd8:  begin w_op_a = r_sxsy_q; w_op_b = w_sz; w_dst = c_r22;  end
            4'd9:  begin w_op_a = w_cx;     w_op_b = w_cz; w_dst = c_r22; w_op = c_op_add; end
            4'd10: begin w_op_a = r_cxsy_q; w_op_b = w_sz; w_dst = c_r23;  end
            4'd11: begin w_op_a = w_sx;     w_op_b = w_cz; w_dst = c_r23; w_op = c_op_sub; end
            4'd12: begin w_op_a = w_sx;     w_op_b = w_cy; w_dst = c_r32;  end
            4'd13: begin w_op_a = w_cx;     w_op_b = w_cy; w_dst = c_r33;  end
            default: begin end
        endcase
        w_prod = mul_fx(w_op_a, w_op_b);
        w_prev = (w_dst <= c_r11) ? r_mtx_q[w_dst] : 32'd0;
        case (w_op)
            c_op_add: w_acc = w_prev + w_prod;
            c_op_sub: w_acc = w_prev - w_prod;
            default:  w_acc = w_prod;
        endcase
    end

    // Control FSM and register next-state logic.
    always_comb begin
        w_state_d     = r_state_q;
        w_tri_d       = r_tri_q;
        w_model_xf_d  = r_model_xf_q;
        w_camera_xf_d = r_camera_xf_q;
        w_cam_flag_d  = r_cam_flag_q;
        w_step_d      = r_step_q;
        w_mtx_d       = r_mtx_q;
        w_sxsy_d      = r_sxsy_q;
        w_cxsy_d      = r_cxsy_q;
        w_model_d     = r_model_q;
        w_camera_d    = r_camera_q;
        w_m_valid_d   = r_m_valid_q;
        w_m_data_d    = r_m_data_q;

        case (r_state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    w_tri_d       = w_in.triangle;
                    w_model_xf_d  = w_in.model;
                    w_camera_xf_d = w_in.camera;
                    w_cam_flag_d  = w_in.camera_transform_valid;
                    if (w_in.model_transform_valid)       w_state_d = ST_BUILD_MODEL;
                    else if (w_in.camera_transform_valid) w_state_d = ST_BUILD_CAMERA;
                    else                                  w_state_d = ST_OUTPUT;
                end
            end
            ST_BUILD_MODEL, ST_BUILD_CAMERA: begin
                w_step_d = r_step_q + 4'd1;
                if (w_dst == c_sxsy)      w_sxsy_d       = w_acc;
                else if (w_dst == c_cxsy) w_cxsy_d       = w_acc;
                else                      w_mtx_d[w_dst] = w_acc;
                if (r_step_q == 4'd0) begin
                    w_mtx_d[c_r31] = 32'd0 - w_sy;
                end
                // Caches commit only on the final step, so a partially built
                // matrix never reaches the output.
                if (r_step_q == c_last_step) begin
                    w_step_d = 4'd0;
                    if (r_state_q == ST_BUILD_MODEL) begin
                        w_model_d.rot_mtx = w_mtx_d;
                        w_model_d.pos     = w_xf.pos;
                        w_model_d.scale   = w_xf.scale;
                        w_state_d = r_cam_flag_q ? ST_BUILD_CAMERA : ST_OUTPUT;
                    end else begin
                        // Camera matrix maps world->camera: inverse rotation
                        // (transpose) and negated translation.
                        w_camera_d.rot_mtx[c_r11] = w_mtx_d[c_r11];
                        w_camera_d.rot_mtx[c_r12] = w_mtx_d[c_r21];
                        w_camera_d.rot_mtx[c_r13] = w_mtx_d[c_r31];
                        w_camera_d.rot_mtx[c_r21] = w_mtx_d[c_r12];
                        w_camera_d.rot_mtx[c_r22] = w_mtx_d[c_r22];
                        w_camera_d.rot_mtx[c_r23] = w_mtx_d[c_r32];
                        w_camera_d.rot_mtx[c_r31] = w_mtx_d[c_r13];
                        w_camera_d.rot_mtx[c_r32] = w_mtx_d[c_r23];
                        w_camera_d.rot_mtx[c_r33] = w_mtx_d[c_r33];
                        w_camera_d.pos.x = 32'd0 - w_xf.pos.x;
                        w_camera_d.pos.y = 32'd0 - w_xf.pos.y;
                        w_camera_d.pos.z = 32'd0 - w_xf.pos.z;
                        w_camera_d.scale = w_xf.scale;
                        w_state_d = ST_OUTPUT;
                    end
                end
            end
            ST_OUTPUT: begin
                // First OUTPUT cycle loads the output register; it then holds
                // until the handshake completes.
                if (!r_m_valid_q) begin
                    w_m_valid_d         = 1'b1;
                    w_m_data_d.triangle = r_tri_q;
                    w_m_data_d.model    = r_model_q;
                    w_m_data_d.camera   = r_camera_q;
                end else if (m_ready) begin
                    w_m_valid_d = 1'b0;
                    w_state_d   = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        w_s_ready_d = (w_state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_tri_q       <= '0;
            r_model_xf_q  <= '0;
            r_camera_xf_q <= '0;
            r_cam_flag_q  <= 1'b0;
            r_step_q      <= '0;
            r_mtx_q       <= '0;
            r_sxsy_q      <= '0;
            r_cxsy_q      <= '0;
            r_model_q     <= c_mtx_reset;
            r_camera_q    <= c_mtx_reset;
            r_s_ready_q   <= 1'b0;
            r_m_valid_q   <= 1'b0;
            r_m_data_q    <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_tri_q       <= w_tri_d;
            r_model_xf_q  <= w_model_xf_d;
            r_camera_xf_q <= w_camera_xf_d;
            r_cam_flag_q  <= w_cam_flag_d;
            r_step_q      <= w_step_d;
            r_mtx_q       <= w_mtx_d;
            r_sxsy_q      <= w_sxsy_d;
            r_cxsy_q      <= w_cxsy_d;
            r_model_q     <= w_model_d;
            r_camera_q    <= w_camera_d;
            r_s_ready_q   <= w_s_ready_d;
            r_m_valid_q   <= w_m_valid_d;
            r_m_data_q    <= w_m_data_d;
        end
    end

    assign s_ready = r_s_ready_q;
    assign m_valid = r_m_valid_q;
    assign m_data  = r_m_data_q;

endmodule
`default_nettype wire

// File: tb/tb_transform_setup_builder.sv
`default_nettype none
// ============================================================================
// Module      : tb_transform_setup_builder
// Description : Self-checking bench for transform_setup_builder. Stimulus
//               pushes the expected output packet and its due cycle into a
//               scoreboard; an independent monitor checks every output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_transform_setup_builder;

    typedef struct packed { logic [31:0] x; logic [31:0] y; logic [31:0] z; } point3d_t;
    typedef struct packed { point3d_t v0; point3d_t v1; point3d_t v2; } triangle_t;
    typedef struct packed {
        point3d_t pos; point3d_t rot_sin; point3d_t rot_cos; point3d_t scale;
    } transform_t;
    typedef struct packed {
        triangle_t triangle; transform_t model; transform_t camera;
        logic model_transform_valid; logic camera_transform_valid;
    } transform_setup_t;
    typedef logic [8:0][31:0] rot_mtx_t;
    typedef struct packed { rot_mtx_t rot_mtx; point3d_t pos; point3d_t scale; } matrix_transform_t;
    typedef struct packed {
        triangle_t triangle; matrix_transform_t model; matrix_transform_t camera;
    } model_world_t;
    typedef struct { logic [1247:0] data; int due; } exp_t;

    localparam logic [31:0] ONE = 32'h0001_0000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [1057:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [1247:0] m_data;

    transform_setup_builder dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_fail = 0;
    int   xfers = 0;
    int   exp_xfers = 0;
    int   last_accept = 0;
    logic hold_ready = 1'b0;
    logic rand_ready = 1'b0;
    exp_t sb[$];
    matrix_transform_t ref_model, ref_camera;

    task automatic check(input string name, input logic [1247:0] act, input logic [1247:0] req);
        n_checks++;
        if (act !== req) begin
            int w;
            n_fail++;
            w = 0;
            for (int i = 0; i < 39; i++) begin
                if (act[i*32 +: 32] !== req[i*32 +: 32]) w = i;
            end
            $display("FAIL %s: word %0d actual=%h required=%h (t=%0t)",
                     name, w, act[w*32 +: 32], req[w*32 +: 32], $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        longint pa, pb, p;
        logic [27:0] ta, tb;
        ta = a[31:4];
        tb = b[31:4];
        pa = longint'($signed(ta));
        pb = longint'($signed(tb));
        p  = (pa * pb) >>> 8;
        return p[31:0];
    endfunction

    function automatic rot_mtx_t euler(input point3d_t s, input point3d_t c);
        logic [31:0] sxsy, cxsy;
        sxsy = fmul(s.x, s.y);
        cxsy = fmul(c.x, s.y);
        return {fmul(c.y, c.z),
                fmul(sxsy, c.z) - fmul(c.x, s.z),
                fmul(cxsy, c.z) + fmul(s.x, s.z),
                fmul(c.y, s.z),
                fmul(sxsy, s.z) + fmul(c.x, c.z),
                fmul(cxsy, s.z) - fmul(s.x, c.z),
                32'd0 - s.y,
                fmul(s.x, c.y),
                fmul(c.x, c.y)};
    endfunction

    function automatic rot_mtx_t transpose(input rot_mtx_t m);
        return {m[8], m[5], m[2], m[7], m[4], m[1], m[6], m[3], m[0]};
    endfunction

    function automatic matrix_transform_t identity();
        matrix_transform_t t;
        t.rot_mtx = {ONE, 32'd0, 32'd0, 32'd0, ONE, 32'd0, 32'd0, 32'd0, ONE};
        t.pos     = '0;
        t.scale   = {ONE, ONE, ONE};
        return t;
    endfunction

    function automatic transform_setup_t rand_pkt();
        logic [1087:0] v;
        for (int i = 0; i < 34; i++) v[i*32 +: 32] = $urandom;
        return v[1057:0];
    endfunction

    // ---------------- stimulus ----------------
    task automatic send(input transform_setup_t p);
        int   waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!s_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!s_ready) begin
            check("s_ready_wait", {1247'd0, s_ready}, {1247'd0, 1'b1});
            return;
        end
        s_valid = 1'b1;
        s_data  = p;
        if (p.model_transform_valid) begin
            ref_model.rot_mtx = euler(p.model.rot_sin, p.model.rot_cos);
            ref_model.pos     = p.model.pos;
            ref_model.scale   = p.model.scale;
        end
        if (p.camera_transform_valid) begin
            ref_camera.rot_mtx = transpose(euler(p.camera.rot_sin, p.camera.rot_cos));
            ref_camera.pos.x   = 32'd0 - p.camera.pos.x;
            ref_camera.pos.y   = 32'd0 - p.camera.pos.y;
            ref_camera.pos.z   = 32'd0 - p.camera.pos.z;
            ref_camera.scale   = p.camera.scale;
        end
        last_accept = cyc + 1;
        e.data = {p.triangle, ref_model, ref_camera};
        e.due  = last_accept + 1 + (p.model_transform_valid ? 14 : 0)
                             + (p.camera_transform_valid ? 14 : 0);
        sb.push_back(e);
        exp_xfers++;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_data  = rand_pkt();
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((sb.size() != 0 || m_valid) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 1248'(sb.size()), 1248'd0);
    endtask

    // m_ready driver
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready)      m_ready = 1'b0;
            else if (rand_ready) m_ready = ($urandom_range(0, 3) != 0);
            else                 m_ready = 1'b1;
        end
    end

    // ---------------- monitor ----------------
    logic          prev_valid = 1'b0;
    logic          prev_ready = 1'b0;
    logic [1247:0] prev_data = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && prev_ready) begin
                check("post_xfer_m_valid", {1247'd0, m_valid}, 1248'd0);
                check("post_xfer_s_ready", {1247'd0, s_ready}, 1248'd1);
            end
            if (m_valid) begin
                check("s_ready_while_valid", {1247'd0, s_ready}, 1248'd0);
                if (!prev_valid) begin
                    if (sb.size() == 0) check("unexpected_m_valid", 1248'd1, 1248'd0);
                    else                check("latency", 1248'(cyc), 1248'(sb[0].due));
                end else if (!prev_ready) begin
                    check("hold_stable", m_data, prev_data);
                end
                if (m_ready && sb.size() != 0) begin
                    check("m_data", m_data, sb[0].data);
                    void'(sb.pop_front());
                    xfers++;
                end
            end
            prev_valid = m_valid;
            prev_ready = m_ready;
            prev_data  = m_data;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    // ---------------- test sequence ----------------
    initial begin
        transform_setup_t p;
        int k;
        ref_model  = identity();
        ref_camera = identity();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_s_ready", {1247'd0, s_ready}, 1248'd0);
        check("reset_m_valid", {1247'd0, m_valid}, 1248'd0);
        check("reset_m_data", m_data, 1248'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_s_ready", {1247'd0, s_ready}, 1248'd1);

        // identity from reset caches
        p = rand_pkt();
        p.model_transform_valid = 1'b0;
        p.camera_transform_valid = 1'b0;
        send(p);
        drain();

        // 90 degrees about z, model
        p = rand_pkt();
        p.model_transform_valid = 1'b1;
        p.camera_transform_valid = 1'b0;
        p.model.rot_sin = {32'd0, 32'd0, ONE};
        p.model.rot_cos = {ONE, ONE, 32'd0};
        send(p);
        drain();

        // camera inverse
        p = rand_pkt();
        p.model_transform_valid = 1'b0;
        p.camera_transform_valid = 1'b1;
        p.camera.rot_sin = {32'd0, 32'd0, ONE};
        p.camera.rot_cos = {ONE, ONE, 32'd0};
        p.camera.pos     = {32'h0002_0000, 32'd0, 32'hFFFF_0000};
        send(p);
        drain();

        // caching: garbage transforms, no flags
        p = rand_pkt();
        p.model_transform_valid = 1'b0;
        p.camera_transform_valid = 1'b0;
        send(p);
        drain();

        // backpressure with both rebuilds
        hold_ready = 1'b1;
        p = rand_pkt();
        p.model_transform_valid = 1'b1;
        p.camera_transform_valid = 1'b1;
        p.camera.pos.x = 32'h8000_0000;
        send(p);
        k = 0;
        while (!m_valid && k < 60) begin
            @(negedge clk);
            k++;
        end
        check("bp_m_valid_rose", {1247'd0, m_valid}, 1248'd1);
        repeat (20) @(negedge clk);
        hold_ready = 1'b0;
        drain();
        check("bp_xfer_count", 1248'(xfers), 1248'(exp_xfers));

        // mid-build reset: reset sampled at edge T+5 of a model build
        p = rand_pkt();
        p.model_transform_valid = 1'b1;
        p.camera_transform_valid = 1'b0;
        send(p);
        while (cyc < last_accept + 4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_xfers = exp_xfers - sb.size();
        sb.delete();
        ref_model  = identity();
        ref_camera = identity();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("midreset_m_valid", {1247'd0, m_valid}, 1248'd0);
        check("midreset_s_ready", {1247'd0, s_ready}, 1248'd0);
        repeat (40) @(negedge clk);
        p = rand_pkt();
        p.model_transform_valid = 1'b0;
        p.camera_transform_valid = 1'b0;
        send(p);
        drain();

        // randomized traffic with random downstream stalls
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            p = rand_pkt();
            p.model_transform_valid  = ($urandom_range(0, 2) == 0);
            p.camera_transform_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) p.camera.pos.y = 32'h8000_0000;
            if ($urandom_range(0, 3) == 0) begin
                p.model.rot_sin = {ONE, 32'hFFFF_0000, 32'h0000_B505};
                p.model.rot_cos = {32'd0, 32'd0, 32'h0000_B505};
            end
            send(p);
        end
        drain();
        rand_ready = 1'b0;
        check("total_xfers", 1248'(xfers), 1248'(exp_xfers));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
